// File: rtl/timer_defs.sv
// Shared constants for the mm:ss countdown timer: per-digit limits, FSM encoding
// and the preset clamp used on load.
package timer_defs;

  localparam logic [3:0] SEC_U_LIM = 4'd9;
  localparam logic [3:0] SEC_T_LIM = 4'd5;
  localparam logic [3:0] MIN_U_LIM = 4'd9;
  localparam logic [3:0] MIN_T_LIM = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Out-of-range preset nibbles saturate at the digit's limit.
  function automatic logic [3:0] clamp_digit(input logic [3:0] val, input logic [3:0] lim);
    logic [3:0] res;
    if (val > lim) begin
      res = lim;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/lim_dec.sv
// Limited decrementor: one BCD-style digit of the borrow chain, wrapping 0 -> L.
module lim_dec #(
  parameter logic [3:0] L = 4'd9
) (
  input  logic [3:0] a,
  input  logic       bi,
  output logic [3:0] diff,
  output logic       bo
);

  // Subtract the borrow-in; a borrow out of zero wraps to the digit limit.
  always_comb begin
    diff = a;
    bo   = 1'b0;
    if (bi && (a == 4'd0)) begin
      diff = L;
      bo   = 1'b1;
    end else if (bi) begin
      diff = a - 4'd1;
      bo   = 1'b0;
    end else begin
      diff = a;
      bo   = 1'b0;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Four-digit mm:ss countdown timer: load/clamp, start/pause FSM, prescaler and
// a four-stage limited-decrementor borrow chain. All outputs are registered.
module countdown_timer
  import timer_defs::*;
#(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] preset,
  input  logic        start_stop,
  output logic [15:0] digits,
  output logic        running,
  output logic        done,
  output logic        expired
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic          tick;
  logic [15:0]   loaded;
  logic [15:0]   dec;
  logic [3:0]    bo;

  assign tick = (state == RUN) && (presc == PRESC_MAX);

  assign loaded = {clamp_digit(preset[15:12], MIN_T_LIM),
                   clamp_digit(preset[11:8],  MIN_U_LIM),
                   clamp_digit(preset[7:4],   SEC_T_LIM),
                   clamp_digit(preset[3:0],   SEC_U_LIM)};

  lim_dec #(.L(SEC_U_LIM)) u_sec_u (.a(digits[3:0]),   .bi(1'b1),  .diff(dec[3:0]),   .bo(bo[0]));
  lim_dec #(.L(SEC_T_LIM)) u_sec_t (.a(digits[7:4]),   .bi(bo[0]), .diff(dec[7:4]),   .bo(bo[1]));
  lim_dec #(.L(MIN_U_LIM)) u_min_u (.a(digits[11:8]),  .bi(bo[1]), .diff(dec[11:8]),  .bo(bo[2]));
  lim_dec #(.L(MIN_T_LIM)) u_min_t (.a(digits[15:12]), .bi(bo[2]), .diff(dec[15:12]), .bo(bo[3]));

  // FSM, prescaler and digit registers; load overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      presc   <= '0;
      digits  <= 16'h0000;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state   <= IDLE;
        presc   <= '0;
        digits  <= loaded;
        running <= 1'b0;
        expired <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_stop && (digits != 16'h0000)) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (tick) begin
              presc <= '0;
              // A borrow out of the top digit would mean ticking from 0000; hold instead.
              digits <= bo[3] ? digits : dec;
              if (digits == 16'h0001) begin
                state   <= DONE;
                running <= 1'b0;
                done    <= 1'b1;
                expired <= 1'b1;
              end else if (start_stop) begin
                state   <= PAUSE;
                running <= 1'b0;
              end
            end else begin
              presc <= presc + PW'(1);
              if (start_stop) begin
                state   <= PAUSE;
                running <= 1'b0;
              end
            end
          end
          PAUSE: begin
            if (start_stop) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
